alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 40 ++++
 rtl/alu_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: op classes, internal
// operation codes and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_OP_LDSD  = 3'b000;
  localparam logic [2:0] ALU_OP_BEQ   = 3'b001;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b010;
  localparam logic [2:0] ALU_OP_ITYPE = 3'b011;
  localparam logic [2:0] ALU_OP_MTYPE = 3'b110;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_SRL = 4'b0100,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1010
  } alu_opc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_MUL   = 2'b10,
    ST_DONE  = 2'b11
  } alu_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of op class plus {funct7[5], funct3} into an
// internal operation code; anything unrecognised falls back to AND.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [3:0] func_alu,
  output alu_opc_e   opc
);

  always_comb begin
    opc = OP_AND;
    case (alu_op)
      ALU_OP_LDSD: opc = OP_ADD;
      ALU_OP_BEQ:  opc = OP_SUB;
      ALU_OP_RTYPE: begin
        case (func_alu)
          4'b0000: opc = OP_ADD;
          4'b1000: opc = OP_SUB;
          4'b0111: opc = OP_AND;
          4'b0110: opc = OP_OR;
          4'b0010: opc = OP_SLT;
          4'b0001: opc = OP_SLL;
          4'b0101: opc = OP_SRL;
          default: opc = OP_AND;
        endcase
      end
      ALU_OP_ITYPE: begin
        case (func_alu[2:0])
          3'b000:  opc = OP_ADD;
          3'b010:  opc = OP_SLT;
          default: opc = OP_AND;
        endcase
      end
      ALU_OP_MTYPE: opc = OP_MUL;
      default:      opc = OP_AND;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle logic/arith, bit-serial shifts and
// shift-add multiply sequenced by a small FSM with a down-counter.
//
// state    | meaning
// ST_IDLE  | waiting for start, result/zero hold
// ST_SHIFT | one shift step per cycle until counter terminal
// ST_MUL   | one multiplier bit per cycle until counter terminal
// ST_DONE  | result valid for one cycle; start may be accepted
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      alu_op,
  input  logic [3:0]      func_alu,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  alu_state_e      state_q, state_d;
  alu_opc_e        opc_q, opc_d, opc_in;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_d;
  logic            res_ld;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mul_sum;
  logic [SW-1:0]   shamt_in;

  alu_op_decode u_decode (
    .alu_op   (alu_op),
    .func_alu (func_alu),
    .opc      (opc_in)
  );

  assign shamt_in = b[SW-1:0];

  function automatic logic [XLEN-1:0] calc(alu_opc_e op, logic [XLEN-1:0] x,
                                           logic [XLEN-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_OR:   return x | y;
      OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      default: return x & y;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = result;
    res_ld  = 1'b0;
    shifted = (opc_q == OP_SRL) ? (opa_q >> 1) : (opa_q << 1);
    mul_sum = acc_q + (opb_q[0] ? opa_q : '0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          opc_d = opc_in;
          case (opc_in)
            OP_SLL, OP_SRL: begin
              if (shamt_in == '0) begin
                state_d = ST_DONE;
                res_d   = a;
                res_ld  = 1'b1;
              end else begin
                state_d = ST_SHIFT;
                opa_d   = a;
                cnt_d   = CW'(shamt_in);
              end
            end
            OP_MUL: begin
              if (MUL_EN) begin
                state_d = ST_MUL;
                acc_d   = '0;
                opa_d   = a;
                opb_d   = b;
                cnt_d   = CW'(XLEN);
              end else begin
                state_d = ST_DONE;
                res_d   = '0;
                res_ld  = 1'b1;
              end
            end
            default: begin
              state_d = ST_DONE;
              res_d   = calc(opc_in, a, b);
              res_ld  = 1'b1;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        opa_d = shifted;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          res_d   = shifted;
          res_ld  = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d = mul_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          res_d   = mul_sum;
          res_ld  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opc_q   <= OP_AND;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      result  <= '0;
      zero    <= 1'b1;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (res_ld) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end

  assign busy = (state_q == ST_SHIFT) || (state_q == ST_MUL);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit at XLEN=32: expected result and
// latency are queued at issue and compared when done appears.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  alu_op;
  logic [3:0]  func_alu;
  logic [31:0] op_a, op_b;
  logic [31:0] result;
  logic        zero, busy, done;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_op   (alu_op),
    .func_alu (func_alu),
    .a        (op_a),
    .b        (op_b),
    .result   (result),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [3:0] fn,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    lat = 1;
    r   = x & y;
    case (op)
      3'b000: r = x + y;
      3'b001: r = x - y;
      3'b010: begin
        case (fn)
          4'b0000: r = x + y;
          4'b1000: r = x - y;
          4'b0110: r = x | y;
          4'b0010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          4'b0001: begin r = x << y[4:0]; lat = int'(y[4:0]) + 1; end
          4'b0101: begin r = x >> y[4:0]; lat = int'(y[4:0]) + 1; end
          default: r = x & y;
        endcase
      end
      3'b011: begin
        if (fn[2:0] == 3'b000)      r = x + y;
        else if (fn[2:0] == 3'b010) r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        else                        r = x & y;
      end
      3'b110: begin r = x * y; lat = 33; end
      default: r = x & y;
    endcase
  endfunction

  // Drive at the current (negedge) time and queue the expectation.
  task automatic issue(input logic [2:0] op, input logic [3:0] fn,
                       input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    model(op, fn, x, y, e.res, e.lat);
    sb.push_back(e);
    start    = 1'b1;
    alu_op   = op;
    func_alu = fn;
    op_a     = x;
    op_b     = y;
  endtask

  // Wait for done; optionally pulse start with junk operands at cycle poke.
  task automatic collect(input string tag, input int poke);
    int   lat  = 0;
    int   bcnt = 0;
    exp_t e;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (lat == poke) begin
        start  = 1'b1;
        alu_op = 3'b000;
        op_a   = 32'd100;
        op_b   = 32'd100;
      end
    end while (!done && lat < 200);
    if (sb.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_val({tag, ".lat"},  64'(lat),  64'(e.lat));
      check_val({tag, ".busy"}, 64'(bcnt), 64'(e.lat - 1));
      check_val({tag, ".res"},  {32'd0, result}, {32'd0, e.res});
      check_val({tag, ".zero"}, {63'd0, zero}, {63'd0, (e.res == 32'd0)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    start = 1'b0; alu_op = 3'b000; func_alu = 4'b0000; op_a = '0; op_b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst.result", {32'd0, result}, 64'd0);
    check_val("rst.zero",   {63'd0, zero}, 64'd1);
    check_val("rst.busy",   {63'd0, busy}, 64'd0);
    check_val("rst.done",   {63'd0, done}, 64'd0);

    rst_n = 1'b1;
    issue(3'b010, 4'b0000, 32'd5, 32'd7);                 collect("add5_7", 0);
    @(negedge clk); issue(3'b001, 4'b0000, 32'h1234, 32'h1234); collect("beq_eq", 0);
    @(negedge clk); issue(3'b010, 4'b0010, 32'hFFFF_FFFF, 32'd1); collect("slt_neg", 0);
    @(negedge clk); issue(3'b000, 4'b0000, 32'hFFFF_FFFF, 32'd2); collect("add_wrap", 0);
    @(negedge clk); issue(3'b010, 4'b1000, 32'd3, 32'd5);         collect("sub_neg", 0);
    @(negedge clk); issue(3'b010, 4'b0110, 32'hF0F0_0000, 32'h0F0F); collect("or", 0);
    @(negedge clk); issue(3'b010, 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0); collect("and", 0);
    @(negedge clk); issue(3'b011, 4'b1000, 32'd10, 32'hFFFF_FFFE); collect("addi", 0);
    @(negedge clk); issue(3'b011, 4'b0010, 32'd4, 32'd4);         collect("slti_eq", 0);
    @(negedge clk); issue(3'b101, 4'b0000, 32'hABCD_1234, 32'h0F0F_0F0F); collect("rsvd", 0);
    @(negedge clk); issue(3'b010, 4'b0001, 32'd1, 32'd4);         collect("sll4", 0);
    @(negedge clk); issue(3'b010, 4'b0101, 32'h8000_0000, 32'd31); collect("srl31", 0);
    @(negedge clk); issue(3'b010, 4'b0001, 32'hDEAD_BEEF, 32'h20); collect("sll0", 0);
    @(negedge clk); issue(3'b110, 4'b0000, 32'd3, 32'd5);         collect("mul3_5", 0);
    @(negedge clk); issue(3'b110, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect("mul_ff", 0);
    @(negedge clk); issue(3'b110, 4'b0000, 32'd7, 32'd9);         collect("mul_poke", 10);
    issue(3'b000, 4'b0000, 32'd2, 32'd2);                         collect("b2b_add", 0);
    issue(3'b010, 4'b0000, 32'd40, 32'd2);                        collect("b2b_add2", 0);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] fns [4];
      fns[0] = 4'b0000; fns[1] = 4'b1000; fns[2] = 4'b0010; fns[3] = 4'b0110;
      @(negedge clk);
      issue(3'b010, fns[i % 4], $urandom, $urandom);
      collect("rnd", 0);
    end

    @(negedge clk); issue(3'b110, 4'b0000, 32'd3, 32'd5);
    repeat (10) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_val("abort.result", {32'd0, result}, 64'd0);
    check_val("abort.zero",   {63'd0, zero}, 64'd1);
    check_val("abort.busy",   {63'd0, busy}, 64'd0);
    check_val("abort.done",   {63'd0, done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check_val("abort.nodone", 64'(ndone), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
